// File: rtl/csa_bist_repair_ctrl_pkg.sv
// Shared types, sizes and the golden conditional-sum cell function for the
// carry-select adder BIST/repair controller.
package csa_bist_pkg;

    typedef enum logic [1:0] {IDLE, APPLY, DECIDE, DONE} state_t;

    localparam int NUM_CSC = 4;
    localparam int CSC_W   = 6;
    localparam int PAT_W   = 4;

    // d = {a_hi, b_hi, a_lo, b_lo}; result packs both carry-in variants
    // interleaved: {c_1, c_0, s_hi_1, s_hi_0, s_lo_1, s_lo_0}.
    function automatic logic [CSC_W-1:0] csc_golden(input logic [PAT_W-1:0] d);
        logic [2:0] s0;
        logic [2:0] s1;
        s0 = {1'b0, d[3], d[1]} + {1'b0, d[2], d[0]};
        s1 = s0 + 3'd1;
        return {s1[2], s0[2], s1[1], s0[1], s1[0], s0[0]};
    endfunction

endpackage

// File: rtl/csa_bist_repair_ctrl_if.sv
// Control/observe bundle between the BIST controller and the adder/host.
// Handshake: start is a level sampled on a rising edge only while the
// controller is in IDLE or DONE; done/result flags are held until the next
// accepted start or rst. There is no backpressure.
interface csa_bist_repair_ctrl_if;
    import csa_bist_pkg::*;

    logic        start;
    logic [23:0] test_output;
    logic        test;
    logic [3:0]  test_data;
    logic [2:0]  is;
    logic [3:0]  ss;
    logic        busy;
    logic        done;
    logic        pass;
    logic        repaired;
    logic        fail;
    logic [3:0]  fault_vec;
    logic [15:0] err_cnt;
    state_t      state;

    modport slave (
        input  start, test_output,
        output test, test_data, is, ss, busy, done, pass, repaired, fail,
               fault_vec, err_cnt, state
    );

    modport master (
        output start, test_output,
        input  test, test_data, is, ss, busy, done, pass, repaired, fail,
               fault_vec, err_cnt, state
    );

endinterface

// File: rtl/csa_repair_map.sv
// Maps the per-cell fault flags to verdict flags and the is/ss steering that
// shifts every cell at or above a single faulty cell one slot toward the spare.
module csa_repair_map
    import csa_bist_pkg::*;
(
    input  logic [NUM_CSC-1:0] fault_vec,
    output logic [2:0]         is,
    output logic [3:0]         ss,
    output logic               pass,
    output logic               repaired,
    output logic               fail
);

    logic [2:0] n_faults;
    logic [1:0] f_idx;

    always_comb begin
        n_faults = '0;
        f_idx    = '0;
        for (int k = 0; k < NUM_CSC; k++) begin
            if (fault_vec[k]) begin
                n_faults = n_faults + 3'd1;
                f_idx    = 2'(k);
            end
        end
    end

    always_comb begin
        pass     = (n_faults == 3'd0);
        repaired = (n_faults == 3'd1);
        fail     = (n_faults >= 3'd2);
        is       = '0;
        ss       = '0;
        if (repaired) begin
            for (int j = 0; j < 3; j++) is[j] = (2'(j) >= f_idx);
            for (int j = 0; j < 4; j++) ss[j] = (2'(j) >= f_idx);
        end
    end

endmodule

// File: rtl/csa_bist_repair_ctrl.sv
// BIST and self-repair sequencer for the 7-bit carry-select adder.
// Optional per-cell saturating mismatch counters: define CSA_ERR_CNT_EN.
module csa_bist_repair_ctrl
    import csa_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int N_PATTERNS    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    csa_bist_repair_ctrl_if.slave  bus
);

    localparam int HOLD_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   pat_q;
    logic [HOLD_W-1:0]  hold_q;
    logic [NUM_CSC-1:0] fault_q;
    logic [2:0]         is_q;
    logic [3:0]         ss_q;
    logic               pass_q, repaired_q, fail_q;

    logic               start_acc, last_hold, last_pat, cmp_en;
    logic [CSC_W-1:0]   golden;
    logic [NUM_CSC-1:0] mismatch;
    logic [2:0]         map_is;
    logic [3:0]         map_ss;
    logic               map_pass, map_repaired, map_fail;

    assign start_acc = bus.start && (state_q == IDLE || state_q == DONE);
    assign last_hold = (hold_q == HOLD_W'(SETTLE_CYCLES - 1));
    assign last_pat  = (pat_q == PAT_W'(N_PATTERNS - 1));
    assign cmp_en    = (state_q == APPLY) && last_hold;

    always_comb begin
        golden   = csc_golden(pat_q);
        mismatch = '0;
        for (int k = 0; k < NUM_CSC; k++)
            mismatch[k] = (bus.test_output[CSC_W*k +: CSC_W] != golden);
    end

    csa_repair_map u_map (
        .fault_vec (fault_q),
        .is        (map_is),
        .ss        (map_ss),
        .pass      (map_pass),
        .repaired  (map_repaired),
        .fail      (map_fail)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_acc) state_d = APPLY;
            APPLY:   if (cmp_en && last_pat) state_d = DECIDE;
            DECIDE:  state_d = DONE;
            DONE:    if (start_acc) state_d = APPLY;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.test  = (state_q == APPLY);
        bus.busy  = (state_q == APPLY) || (state_q == DECIDE);
        bus.done  = (state_q == DONE);
        bus.state = state_q;
    end

    // pat_q doubles as test_data; it wraps to 0 on leaving APPLY so the
    // adder sees a zero pattern during DECIDE and DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q      <= '0;
            hold_q     <= '0;
            fault_q    <= '0;
            is_q       <= '0;
            ss_q       <= '0;
            pass_q     <= 1'b0;
            repaired_q <= 1'b0;
            fail_q     <= 1'b0;
        end else if (start_acc) begin
            pat_q      <= '0;
            hold_q     <= '0;
            fault_q    <= '0;
            pass_q     <= 1'b0;
            repaired_q <= 1'b0;
            fail_q     <= 1'b0;
        end else if (state_q == APPLY) begin
            if (last_hold) begin
                hold_q  <= '0;
                fault_q <= fault_q | mismatch;
                pat_q   <= last_pat ? '0 : pat_q + 1'b1;
            end else begin
                hold_q  <= hold_q + 1'b1;
            end
        end else if (state_q == DECIDE) begin
            is_q       <= map_is;
            ss_q       <= map_ss;
            pass_q     <= map_pass;
            repaired_q <= map_repaired;
            fail_q     <= map_fail;
        end
    end

    assign bus.test_data = pat_q;
    assign bus.is        = is_q;
    assign bus.ss        = ss_q;
    assign bus.pass      = pass_q;
    assign bus.repaired  = repaired_q;
    assign bus.fail      = fail_q;
    assign bus.fault_vec = fault_q;

`ifdef CSA_ERR_CNT_EN
    logic [4*NUM_CSC-1:0] err_q;

    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            err_q <= '0;
        end else if (cmp_en) begin
            for (int k = 0; k < NUM_CSC; k++)
                if (mismatch[k] && err_q[4*k +: 4] != 4'hF)
                    err_q[4*k +: 4] <= err_q[4*k +: 4] + 4'd1;
        end
    end

    assign bus.err_cnt = err_q;
`else
    assign bus.err_cnt = '0;
`endif

endmodule

// File: tb/tb_csa_bist_repair_ctrl.sv
// Self-checking bench for csa_bist_repair_ctrl with a fault-injectable adder model.
module tb_csa_bist_repair_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  csa_bist_repair_ctrl_if bus();

  csa_bist_repair_ctrl #(.SETTLE_CYCLES(1), .N_PATTERNS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_mis = 0;

  // current adder fault configuration
  logic [3:0]  cur_fe = '0;
  logic [15:0] cur_fv = '0;
  logic [23:0] cur_s1 = '0;
  logic [23:0] cur_s0 = '0;
  logic [2:0]  prev_is = '0;
  logic [3:0]  prev_ss = '0;

  // {fault_vec, pass, repaired, fail, is, ss, err_cnt}
  logic [29:0] exp_q[$];

  typedef struct {
    logic [3:0]  fe;
    logic [15:0] fv;
    logic [23:0] s1;
    logic [23:0] s0;
    logic [3:0]  exp_fault;
    logic        exp_pass;
    logic        exp_rep;
    logic        exp_fail;
    logic [2:0]  exp_is;
    logic [3:0]  exp_ss;
    logic [15:0] exp_err;
  } vec_t;

  vec_t tbl[6];

  function automatic logic [5:0] gold(input logic [3:0] d);
    int a, b, s0, s1;
    a  = 2 * int'(d[3]) + int'(d[1]);
    b  = 2 * int'(d[2]) + int'(d[0]);
    s0 = a + b;
    s1 = a + b + 1;
    return {s1 >= 4, s0 >= 4, ((s1 / 2) % 2) == 1, ((s0 / 2) % 2) == 1,
            (s1 % 2) == 1, (s0 % 2) == 1};
  endfunction

  function automatic logic [23:0] adder_out(input logic [3:0] d, input logic [3:0] fe,
                                            input logic [15:0] fv, input logic [23:0] s1,
                                            input logic [23:0] s0);
    logic [23:0] r;
    for (int k = 0; k < 4; k++)
      r[6*k +: 6] = gold(fe[k] ? fv[4*k +: 4] : d);
    return (r | s1) & ~s0;
  endfunction

  always_comb bus.test_output = adder_out(bus.test_data, cur_fe, cur_fv, cur_s1, cur_s0);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: run all 16 patterns through the faulty adder, count bad cells.
  task automatic model(input logic [3:0] fe, input logic [15:0] fv,
                       input logic [23:0] s1, input logic [23:0] s0);
    int cnt[4];
    int nf, f;
    logic [3:0]  fvec;
    logic [2:0]  e_is;
    logic [3:0]  e_ss;
    logic [15:0] e_err;
    logic [23:0] o;
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    for (int p = 0; p < 16; p++) begin
      o = adder_out(4'(p), fe, fv, s1, s0);
      for (int k = 0; k < 4; k++)
        if (o[6*k +: 6] != gold(4'(p))) cnt[k]++;
    end
    nf = 0; f = 0; e_is = '0; e_ss = '0;
    for (int k = 0; k < 4; k++) begin
      fvec[k] = (cnt[k] != 0);
      e_err[4*k +: 4] = 4'((cnt[k] > 15) ? 15 : cnt[k]);
      if (cnt[k] != 0) begin nf++; f = k; end
    end
    if (nf == 1) begin
      e_is = 3'(7 << f);
      e_ss = 4'(15 << f);
    end
    exp_q.push_back({fvec, nf == 0, nf == 1, nf >= 2, e_is, e_ss, e_err});
  endtask

  task automatic check_fields(input logic [3:0] fvec, input logic p, input logic r,
                              input logic f, input logic [2:0] e_is,
                              input logic [3:0] e_ss, input logic [15:0] e_err);
    check("fault_vec", 32'(bus.fault_vec), 32'(fvec));
    check("pass", 32'(bus.pass), 32'(p));
    check("repaired", 32'(bus.repaired), 32'(r));
    check("fail", 32'(bus.fail), 32'(f));
    check("is", 32'(bus.is), 32'(e_is));
    check("ss", 32'(bus.ss), 32'(e_ss));
`ifdef CSA_ERR_CNT_EN
    check("err_cnt", 32'(bus.err_cnt), 32'(e_err));
`else
    check("err_cnt", 32'(bus.err_cnt), 32'(e_err & 16'h0));
`endif
    prev_is = e_is;
    prev_ss = e_ss;
  endtask

  task automatic run_sweep(input logic [3:0] fe, input logic [15:0] fv,
                           input logic [23:0] s1, input logic [23:0] s0, input bit repulse);
    int edge_n, tcyc;
    @(negedge clk);
    cur_fe = fe; cur_fv = fv; cur_s1 = s1; cur_s0 = s0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    edge_n = 0;
    tcyc   = int'(bus.test);
    check("start_done_clr", 32'(bus.done), 32'd0);
    check("start_flags_clr", 32'({bus.pass, bus.repaired, bus.fail, bus.fault_vec}), 32'd0);
    check("start_err_clr", 32'(bus.err_cnt), 32'd0);
    check("start_busy", 32'(bus.busy), 32'd1);
    check("sweep_is_hold", 32'(bus.is), 32'(prev_is));
    check("sweep_ss_hold", 32'(bus.ss), 32'(prev_ss));
    while (bus.done !== 1'b1 && edge_n < 60) begin
      @(posedge clk); #1;
      edge_n++;
      tcyc += int'(bus.test);
      if (repulse) bus.start = (edge_n == 4);
    end
    bus.start = 1'b0;
    check("done_cycle", 32'(edge_n + 1), 32'd18);
    check("test_cycles", 32'(tcyc), 32'd16);
    check("busy_at_done", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [29:0] e;
    logic [3:0]  fe;
    logic [15:0] fv;
    logic [23:0] s1, s0;

    // fe, fv, s1, s0, fault_vec, pass, rep, fail, is, ss, err_cnt
    tbl[0] = '{4'h0, 16'h0000, 24'h0,      24'h0,      4'b0000, 1, 0, 0, 3'b000, 4'b0000, 16'h0000};
    tbl[1] = '{4'h2, 16'h0000, 24'h0,      24'h0,      4'b0010, 0, 1, 0, 3'b110, 4'b1110, 16'h00F0};
    tbl[2] = '{4'h0, 16'h0000, 24'h800000, 24'h0,      4'b1000, 0, 1, 0, 3'b000, 4'b1000, 16'h6000};
    tbl[3] = '{4'h0, 16'h0000, 24'h0,      24'h03F03F, 4'b0101, 0, 0, 1, 3'b000, 4'b0000, 16'h0F0F};
    tbl[4] = '{4'h0, 16'h0000, 24'h0,      24'h000001, 4'b0001, 0, 1, 0, 3'b111, 4'b1111, 16'h0008};
    tbl[5] = '{4'h4, 16'h0F00, 24'h0,      24'h0,      4'b0100, 0, 1, 0, 3'b100, 4'b1100, 16'h0F00};

    rst = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_test", 32'(bus.test), 32'd0);
    check("rst_test_data", 32'(bus.test_data), 32'd0);
    check("rst_busy_done", 32'({bus.busy, bus.done}), 32'd0);
    check_fields(4'b0, 1'b0, 1'b0, 1'b0, 3'b000, 4'b0000, 16'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_sweep(tbl[i].fe, tbl[i].fv, tbl[i].s1, tbl[i].s0, 1'b0);
      check_fields(tbl[i].exp_fault, tbl[i].exp_pass, tbl[i].exp_rep, tbl[i].exp_fail,
                   tbl[i].exp_is, tbl[i].exp_ss, tbl[i].exp_err);
    end

    for (int i = 0; i < 20; i++) begin
      fe = '0; fv = '0; s1 = '0; s0 = '0;
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(0, 6))
          0: begin fe[k] = 1'b1; fv[4*k +: 4] = 4'($urandom_range(0, 15)); end
          1: s1[6*k + $urandom_range(0, 5)] = 1'b1;
          2: s0[6*k + $urandom_range(0, 5)] = 1'b1;
          default: ;
        endcase
      end
      model(fe, fv, s1, s0);
      run_sweep(fe, fv, s1, s0, 1'b0);
      e = exp_q.pop_front();
      check_fields(e[29:26], e[25], e[24], e[23], e[22:20], e[19:16], e[15:0]);
    end

    // start re-pulsed mid-APPLY must not disturb the sweep
    model(4'h2, 16'h0000, 24'h0, 24'h0);
    run_sweep(4'h2, 16'h0000, 24'h0, 24'h0, 1'b1);
    e = exp_q.pop_front();
    check_fields(e[29:26], e[25], e[24], e[23], e[22:20], e[19:16], e[15:0]);

    // rst asserted in sweep cycle 8 aborts everything
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_test", 32'(bus.test), 32'd0);
    check("abort_busy_done", 32'({bus.busy, bus.done}), 32'd0);
    check_fields(4'b0, 1'b0, 1'b0, 1'b0, 3'b000, 4'b0000, 16'h0);

    run_sweep(4'h0, 16'h0000, 24'h0, 24'h0, 1'b0);
    check_fields(4'b0, 1'b1, 1'b0, 1'b0, 3'b000, 4'b0000, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
